// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM-side control blocks: duty width and ramp FSM states.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_tick.sv
// Free-running PWM period counter with a decode of the last cycle of each period.
module pwm_period_tick #(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_period_end
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= r_cnt + 1'b1;
  end

  assign o_period_end = (r_cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer for the pwm block: ramps duty toward a commanded target by at
// most one step per PWM period, with abort and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for a command, duty held
// RAMP  | stepping duty toward target on each period end
// DONE  | target reached, done pulse for one cycle
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_target,
  input  logic [WIDTH-1:0] i_cmd_step,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_period_end,
  output logic             o_busy,
  output logic             o_done
);

  ramp_state_t      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_duty, w_duty_nxt;
  logic [WIDTH-1:0] r_tgt, r_stp;
  logic             w_load;
  logic             w_period_end;
  logic             w_up;
  logic [WIDTH:0]   w_diff;

  pwm_period_tick #(.WIDTH(WIDTH)) u_tick (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_period_end (w_period_end)
  );

  assign w_up   = (r_tgt > r_duty);
  assign w_diff = w_up ? ({1'b0, r_tgt} - {1'b0, r_duty}) : ({1'b0, r_duty} - {1'b0, r_tgt});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_stp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      if (w_load) begin
        r_tgt <= i_cmd_target;
        r_stp <= i_cmd_step;
      end
    end
  end

  // A step strictly smaller than the remaining distance can never overshoot or wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_load      = 1'b1;
          w_state_nxt = (i_cmd_target == r_duty) ? DONE : RAMP;
        end
      end
      RAMP: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
        end else if (w_period_end) begin
          if ((r_stp == '0) || (w_diff <= {1'b0, r_stp})) begin
            w_duty_nxt  = r_tgt;
            w_state_nxt = DONE;
          end else begin
            w_duty_nxt = w_up ? (r_duty + r_stp) : (r_duty - r_stp);
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_cmd_ready  = (r_state == IDLE);
  assign o_busy       = (r_state == RAMP);
  assign o_done       = (r_state == DONE);
  assign o_duty       = r_duty;
  assign o_period_end = w_period_end;

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer for the 8-bit `pwm` block. It accepts a target duty and step size over a valid/ready handshake and drives the `pwm` `din` input. The duty ramps toward the target by at most one step per 256-cycle PWM period, so the output never jumps abruptly. It sits between a host/register interface and the `pwm` instance, and its `duty` output connects directly to `pwm.din`.

## Interface
- `WIDTH`, default 8: duty width. PWM period is 2**`WIDTH` cycles.
- `clk` input 1: single clock, shared with `pwm`.
- `rst_n` input 1: reset, synchronous, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command (IDLE only).
- `cmd_target` input `WIDTH`: final duty value.
- `cmd_step` input `WIDTH`: maximum change per period; 0 means jump directly to target.
- `abort` input 1: stop the ramp and hold the current duty.
- `duty` output `WIDTH`: drives `pwm.din`.
- `period_end` output 1: high on the last cycle of each period.
- `busy` output 1: ramp in progress.
- `done` output 1: one-cycle pulse when `duty` reaches the target.

## Operation
- **Period counter `cnt`.**
  - `WIDTH` bits, free-running, increments every cycle and wraps 2**`WIDTH`-1 to 0.
  - `period_end` = (`cnt` == 2**`WIDTH`-1).
- **FSM states:** IDLE, RAMP, DONE.
- **IDLE.**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch `cmd_target` and `cmd_step` into `tgt` and `stp`.
  - If `tgt` == `duty`, go to DONE; else go to RAMP.
- **RAMP.**
  - `busy`=1 and `cmd_ready`=0; `cmd_valid` is ignored.
  - On `period_end`, compute `diff` = |`tgt` - `duty`| in `WIDTH`+1 bits.
  - If `stp`==0 or `diff` <= `stp`, set `duty` to `tgt` and go to DONE.
  - Otherwise, `duty` moves by `stp` toward `tgt`. It never overshoots and never wraps: 0 and 2**`WIDTH`-1 are hard limits.
- **DONE.** `done`=1 for exactly one cycle, then IDLE.
- **abort.**
  - In RAMP, go to IDLE with `duty` held at its current value; no `done` pulse.
  - Ignored in IDLE and DONE.
- **Simultaneous abort and `period_end` in RAMP:** abort wins and no duty update occurs.
- **Mid-period command acceptance:** the first update waits for the next `period_end`. There is no partial-period step.
- **Reset** (any state, including mid-ramp):
  - `duty`=0, `cnt`=0, state=IDLE.
  - `tgt`=0 and `stp`=0.
- **Output reset values:** `cmd_ready`=1, `busy`=0, `done`=0, `period_end`=0.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- **Command accept to state change:** state changes on the edge that samples valid&&ready.
  - `cmd_ready` drops the next cycle.
  - If `tgt` == `duty` at accept, `done` is high the cycle after accept.
- **Duty updates:** `duty` updates only on an edge where `period_end`=1. The new value is visible while `cnt`=0, so each value is held for whole periods.
- **Final step:** `done` is high in the same cycle the final `duty` value first appears (`cnt`=0). `cmd_ready` returns to 1 the cycle after `done`.
- **Back-to-back commands:** the earliest next accept is 2 cycles after the final update edge.
- **Ramp latency:** ceil(|target - start| / step) periods, plus up to one partial period before the first update.

## Structure
- **Shared package `pwm_pkg`:**
  - `PWM_WIDTH` = 8.
  - FSM state enum `ramp_state_t` {IDLE, RAMP, DONE}.
- **Sub-module `pwm_period_tick`:** the period counter plus the `period_end` decode. It is reusable by future PWM-side blocks.
- **Top-level integration:** `pwm_ramp_ctrl` and `pwm` both connect to the same `clk`.

## Test plan
- **Reset state:** hold `rst_n`=0 for 5 cycles, then release.
  - During reset: `duty`=0, `cmd_ready`=1, `busy`=0, `done`=0.
  - After release: `period_end` first pulses at cycle 255.
- **Up-ramp:** from `duty`=0, send target=100, step=30.
  - `duty` = 30, 60, 90, 100 at four consecutive period starts.
  - `done` pulses once, with `duty`=100.
- **Down-ramp with saturation:** from 100, send target=0, step=40.
  - `duty` = 60, 20, 0; no wrap below 0.
  - Then send target=255, step=0: `duty`=255 at the next period start.
- **Abort:** during a 0→200 step 50 ramp, assert `abort` after `duty`=100 on the cycle where `period_end`=1.
  - `duty` stays at 100; no `done`; `cmd_ready`=1 the next cycle.
- **Reset mid-ramp and ignored commands:**
  - Drive `cmd_valid` during RAMP with target=7: the command is ignored.
  - Assert `rst_n`=0 mid-ramp: `duty`=0 and state=IDLE on the next edge.
- **Equal target:** with `duty`=60, send target=60.
  - `done` the cycle after accept; no `busy`.
